// File: rtl/agu_pkg.sv
// -----------------------------------------------------------------------------
// agu_pkg
// Shared definitions for the address generation unit and its job sequencer.
//   - Width defaults shared with the AGU (address/jump width, length width)
//   - Total step-count width default used by agu_ctrl
//   - Sequencer state encoding
// -----------------------------------------------------------------------------
package agu_pkg;

    localparam int BWADDR_DEF   = 21;
    localparam int BWLENGTH_DEF = 8;
    localparam int BWCOUNT_DEF  = 24;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } agu_state_e;

endpackage

// File: rtl/agu_ctrl.sv
// -----------------------------------------------------------------------------
// agu_ctrl
// Job sequencer sitting directly upstream of the AGU. Accepts one loop
// descriptor over a valid/ready handshake, clears the AGU for one cycle, then
// issues cmd_cnt step pulses, pausing while the memory side stalls. Flags the
// final step (last) and pulses done when the job finishes.
//
// Optional feature (macro AGU_CTRL_ABORT_EN): adds an abort input that kills
// a job in LOAD or RUN, clears the AGU that same cycle and returns to IDLE
// without a done pulse.
//
// Ports
//   clk, clr              clock; synchronous active-high reset
//   cmd_vld / cmd_rdy     descriptor handshake (accept = cmd_vld & cmd_rdy)
//   cmd_l0..l3, j0..j4    descriptor lengths / jumps
//   cmd_cnt               total number of steps to issue
//   stall                 memory side cannot take an address this cycle
//   abort                 job abort (only with AGU_CTRL_ABORT_EN)
//   agu_clr, agu_step     AGU control pulses
//   agu_l0..l3, j0..j4    latched descriptor fields to the AGU
//   last                  high together with the final agu_step
//   busy                  job in progress
//   done                  one-cycle completion pulse
// -----------------------------------------------------------------------------
module agu_ctrl
    import agu_pkg::*;
#(
    parameter int BWADDR   = BWADDR_DEF,
    parameter int BWLENGTH = BWLENGTH_DEF,
    parameter int BWCOUNT  = BWCOUNT_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [BWLENGTH-1:0] cmd_l0,
    input  logic [BWLENGTH-1:0] cmd_l1,
    input  logic [BWLENGTH-1:0] cmd_l2,
    input  logic [BWLENGTH-1:0] cmd_l3,
    input  logic [BWADDR-1:0]   cmd_j0,
    input  logic [BWADDR-1:0]   cmd_j1,
    input  logic [BWADDR-1:0]   cmd_j2,
    input  logic [BWADDR-1:0]   cmd_j3,
    input  logic [BWADDR-1:0]   cmd_j4,
    input  logic [BWCOUNT-1:0]  cmd_cnt,
    input  logic                stall,
`ifdef AGU_CTRL_ABORT_EN
    input  logic                abort,
`endif
    output logic                agu_clr,
    output logic                agu_step,
    output logic [BWLENGTH-1:0] agu_l0,
    output logic [BWLENGTH-1:0] agu_l1,
    output logic [BWLENGTH-1:0] agu_l2,
    output logic [BWLENGTH-1:0] agu_l3,
    output logic [BWADDR-1:0]   agu_j0,
    output logic [BWADDR-1:0]   agu_j1,
    output logic [BWADDR-1:0]   agu_j2,
    output logic [BWADDR-1:0]   agu_j3,
    output logic [BWADDR-1:0]   agu_j4,
    output logic                last,
    output logic                busy,
    output logic                done
);

    agu_state_e         state, state_nxt;
    logic [BWCOUNT-1:0] remaining;
    logic               accept;
    logic               abort_act;

`ifdef AGU_CTRL_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    // Handshake and status are decoded from state only.
    assign cmd_rdy = (state == S_IDLE);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign accept  = cmd_vld & cmd_rdy;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        agu_step  = 1'b0;
        agu_clr   = clr;     // AGU is cleared alongside our own reset
        last      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                agu_clr = 1'b1;
                if (abort_act)            state_nxt = S_IDLE;
                else if (remaining == '0) state_nxt = S_DONE;
                else                      state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort_act) begin
                    agu_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    // stall has zero-latency effect on the step pulse.
                    agu_step = ~stall;
                    if (agu_step && remaining == BWCOUNT'(1)) begin
                        last      = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            remaining <= '0;
            agu_l0    <= '0;
            agu_l1    <= '0;
            agu_l2    <= '0;
            agu_l3    <= '0;
            agu_j0    <= '0;
            agu_j1    <= '0;
            agu_j2    <= '0;
            agu_j3    <= '0;
            agu_j4    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Descriptor is held from here until the next accept.
                remaining <= cmd_cnt;
                agu_l0    <= cmd_l0;
                agu_l1    <= cmd_l1;
                agu_l2    <= cmd_l2;
                agu_l3    <= cmd_l3;
                agu_j0    <= cmd_j0;
                agu_j1    <= cmd_j1;
                agu_j2    <= cmd_j2;
                agu_j3    <= cmd_j3;
                agu_j4    <= cmd_j4;
            end else if (agu_step) begin
                remaining <= remaining - BWCOUNT'(1);
            end
        end
    end

endmodule

// File: doc/agu_ctrl.md
# agu_ctrl

Job sequencer placed directly upstream of the address generation unit. It accepts a loop descriptor through a valid/ready handshake and latches it. It then clears the AGU and issues a programmed number of step pulses, pausing whenever the memory side asserts stall. It signals the final step and job completion to the owning MVU controller.

## Interface
Parameters:
- BWADDR, 21, address/jump width (matches AGU)
- BWLENGTH, 8, per-dimension length width (matches AGU)
- BWCOUNT, 24, total step-count width

Ports:
- clk  in  1  clock
- clr  in  1  reset, synchronous, active-high
- cmd_vld  in  1  descriptor valid
- cmd_rdy  out  1  descriptor accepted when cmd_vld & cmd_rdy
- cmd_l0..cmd_l3  in  BWLENGTH each  dimension lengths
- cmd_j0..cmd_j4  in  BWADDR each  dimension jumps
- cmd_cnt  in  BWCOUNT  total steps to issue
- stall  in  1  memory side cannot take an address this cycle
- agu_clr  out  1  clear pulse to AGU
- agu_step  out  1  step to AGU
- agu_l0..agu_l3, agu_j0..agu_j4  out  latched descriptor fields
- last  out  1  high with the final agu_step of a job
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - cmd_rdy=1.
  - On accept: latch every cmd_* field; remaining <= cmd_cnt; go to LOAD.
- **LOAD** (exactly one cycle)
  - agu_clr=1.
  - remaining==0 → DONE; else → RUN.
- **RUN**
  - agu_step = ~stall (combinational).
  - On each step: remaining <= remaining-1.
  - When remaining==1 and step: last=1; next state DONE.
  - stall held high: stays in RUN indefinitely, no step, remaining unchanged.
- **DONE**
  - done=1 for one cycle; → IDLE.
- busy = state != IDLE.
- cmd_rdy=0 outside IDLE; cmd_vld is ignored there, and descriptors are never queued.
- Latched agu_l*/agu_j* are held stable from LOAD through DONE, and remain held in IDLE until the next accept.
- Arithmetic:
  - remaining is BWCOUNT bits, unsigned.
  - cmd_cnt=0 is legal and produces no steps.
  - Maximum job length is 2^BWCOUNT-1.
- Reset (clr=1), including mid-job, takes effect at the next edge:
  - state=IDLE, remaining=0, all latched fields 0.
  - agu_clr=1 during the clr cycle, so the AGU is cleared alongside.
  - No done pulse is produced.

## Timing
- Accept at edge N → agu_clr high in cycle N+1 → first possible agu_step in cycle N+2.
- A job of C steps with no stall: done is high in cycle N+2+C, and cmd_rdy returns in cycle N+3+C.
- stall → agu_step has zero latency (combinational). All other outputs are registered or decoded from state only.
- last and agu_step are asserted together. last is never high without agu_step.
- Reset values of outputs:
  - cmd_rdy=1, busy=0, done=0, agu_step=0, last=0, descriptor outputs 0.
  - agu_clr=1 while clr is high, then 0 after release.

## Configuration
- Macro AGU_CTRL_ABORT_EN.
- **Defined:**
  - Adds input abort (1 bit).
  - abort high in LOAD or RUN: the same cycle forces agu_step=0 and agu_clr=1; next state is IDLE with no done pulse.
  - abort in IDLE or DONE is ignored.
  - clr has priority over abort.
- **Undefined:**
  - Port absent; jobs always run to completion or reset.

## Structure
- Shared package agu_pkg:
  - state enum (IDLE, LOAD, RUN, DONE)
  - width constants shared with the AGU (BWADDR, BWLENGTH defaults)
  - BWCOUNT default
- No sub-module: the down-counter and FSM are local to the block.
- The AGU itself is instantiated by the parent, which wires agu_* outputs to AGU inputs.

## Test plan
- **Basic job:** cnt=5, no stall, accept at cycle 0 → agu_clr at 1; agu_step at 2–6; last at 6; done at 7; cmd_rdy at 8.
- **Zero count:** cnt=0 → agu_clr at 1, done at 2, no agu_step, no last.
- **Stall:** cnt=3, stall high cycles 3–5 → steps at 2, 6, 7; last at 7; done at 8; remaining frozen during stall.
- **Back-to-back:** cmd_vld held high with a second descriptor → second accepted only in the cycle cmd_rdy=1; descriptor outputs change only on that accept.
- **Mid-job reset:** cnt=100, clr at step 10 → next cycle IDLE, busy=0, outputs at reset values, no done; new job then runs normally.
- **Abort (AGU_CTRL_ABORT_EN defined):** abort during RUN with stall=0 → no step in that cycle, agu_clr=1, IDLE next cycle, no done.
